imem_boot_loader: RTL

Boot-time loader sitting directly upstream of the single-cycle core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially into the core's instruction memory. It holds the core in reset until the image is fully written, then releases it. With the checksum feature enabled, a bad image keeps the core in reset permanently.

---
 rtl/imem_boot_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into words, writes them to imem, then releases the core.
// Define BOOT_CHECKSUM_EN to require a trailing checksum word (N + sum of payload) before release.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  done,
  output logic                  error
);

  // state  | meaning
  // S_HDR  | collecting the 32-bit word count N
  // S_LOAD | collecting and writing N payload words
  // S_CHK  | collecting the checksum word (checksum build only)
  // S_DONE | image loaded, core released (terminal)
  // S_ERR  | load aborted, core held in reset (terminal)
`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {S_HDR, S_LOAD, S_CHK, S_DONE, S_ERR} state_t;
  localparam state_t S_TAIL = S_CHK;
`else
  typedef enum logic [2:0] {S_HDR, S_LOAD, S_DONE, S_ERR} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [1:0]            lane_q;
  logic [23:0]           byte_buf_q;
  logic [ADDR_WIDTH:0]   word_cnt_q;
  logic [31:0]           n_q;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]           acc_q;
`endif

  logic        accept;
  logic        word_done;
  logic [31:0] word;
  logic        last_word;
  logic        oversize;
  logic        ready_d, we_d, done_d, error_d, rstn_d;

  assign accept    = in_valid && in_ready;
  assign word_done = accept && (lane_q == 2'd3);
  assign word      = {in_data, byte_buf_q};
  assign last_word = (32'(word_cnt_q) == n_q - 32'd1);
  assign oversize  = ({1'b0, word} > CAP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_HDR;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready   <= ready_d;
      imem_we    <= we_d;
      done       <= done_d;
      error      <= error_d;
      core_rst_n <= rstn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR: begin
        if (word_done) begin
          if (word == 32'd0)  state_d = S_TAIL;
          else if (oversize)  state_d = S_ERR;
          else                state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (word_done && last_word) state_d = S_TAIL;
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK: begin
        if (word_done) state_d = (word == acc_q) ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase
  end

  // in_ready and error follow the state being entered; done/release lag DONE by one edge.
  always_comb begin
    ready_d = (state_d != S_DONE) && (state_d != S_ERR);
    we_d    = word_done && (state_q == S_LOAD);
    done_d  = (state_q == S_DONE);
    rstn_d  = (state_q == S_DONE);
    error_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_q     <= 2'd0;
      byte_buf_q <= 24'd0;
      word_cnt_q <= '0;
      n_q        <= 32'd0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
      acc_q      <= 32'd0;
`endif
    end else begin
      if (accept) begin
        lane_q <= lane_q + 2'd1;
        case (lane_q)
          2'd0:    byte_buf_q[7:0]   <= in_data;
          2'd1:    byte_buf_q[15:8]  <= in_data;
          2'd2:    byte_buf_q[23:16] <= in_data;
          default: ;
        endcase
      end
      if (word_done && (state_q == S_HDR)) n_q <= word;
      if (we_d) begin
        imem_addr  <= word_cnt_q[ADDR_WIDTH-1:0];
        imem_wdata <= word;
        word_cnt_q <= word_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
`ifdef BOOT_CHECKSUM_EN
      if (word_done && (state_q == S_HDR))  acc_q <= word;
      if (word_done && (state_q == S_LOAD)) acc_q <= acc_q + word;
`endif
    end
  end

endmodule
